// File: rtl/pmc_dump_controller.sv
`default_nettype none
// ============================================================================
// Module   : pmc_dump_controller
// Purpose  : Snapshots the four PMC counters and streams them as 32-bit words
//            over a valid/ready write port, with an optional PMC clear.
// Revision : 1.0 - initial release
// ============================================================================
module pmc_dump_controller #(
    parameter int               CNT_W     = 256,
    parameter int               WORD_W    = 32,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_req,
    input  logic              clear_after,
    input  logic [CNT_W-1:0]  stall_count,
    input  logic [CNT_W-1:0]  cycles_per_instruction_q78,
    input  logic [CNT_W-1:0]  arith_count,
    input  logic [CNT_W-1:0]  mem_access_count,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [WORD_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              pmc_clr,
    output logic              busy,
    output logic              done
);

    localparam int c_WORDS_PER_CNT = CNT_W / WORD_W;
    localparam int c_NUM_WORDS     = 4 * c_WORDS_PER_CNT;
    localparam int c_IDX_W         = $clog2(c_NUM_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_NUM_WORDS - 1);
    localparam logic [WORD_W-1:0]  c_ADDR_STEP = WORD_W'(WORD_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_clr_pending;
    logic [4*CNT_W-1:0]   r_snapshot;
    logic [c_IDX_W-1:0]   w_next_idx;

    assign w_next_idx = r_idx + c_IDX_W'(1);

    // Address and data are registered and preloaded one word ahead, so they
    // hold stable under backpressure and never depend on wr_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_clr_pending <= 1'b0;
            r_snapshot    <= '0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            pmc_clr       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            pmc_clr <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dump_req) begin
                        r_snapshot    <= {mem_access_count, arith_count,
                                          cycles_per_instruction_q78, stall_count};
                        r_idx         <= '0;
                        r_clr_pending <= clear_after;
                        wr_valid      <= 1'b1;
                        wr_addr       <= BASE_ADDR;
                        wr_data       <= stall_count[WORD_W-1:0];
                        busy          <= 1'b1;
                        r_state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wr_ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            wr_valid <= 1'b0;
                            wr_addr  <= '0;
                            wr_data  <= '0;
                            if (r_clr_pending) begin
                                pmc_clr <= 1'b1;
                                r_state <= ST_CLEAR;
                            end else begin
                                done    <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_idx   <= w_next_idx;
                            wr_addr <= wr_addr + c_ADDR_STEP;
                            wr_data <= r_snapshot[w_next_idx*WORD_W +: WORD_W];
                        end
                    end
                end
                ST_CLEAR: begin
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmc_dump_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmc_dump_controller
// Purpose  : Directed, table-checked bench for pmc_dump_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmc_dump_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         dump_req;
    logic         clear_after;
    logic [255:0] stall_count;
    logic [255:0] cpi;
    logic [255:0] arith_count;
    logic [255:0] mem_count;
    logic         wr_ready;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         pmc_clr;
    logic         busy;
    logic         done;

    pmc_dump_controller dut (
        .clk                        (clk),
        .reset                      (reset),
        .dump_req                   (dump_req),
        .clear_after                (clear_after),
        .stall_count                (stall_count),
        .cycles_per_instruction_q78 (cpi),
        .arith_count                (arith_count),
        .mem_access_count           (mem_count),
        .wr_ready                   (wr_ready),
        .wr_valid                   (wr_valid),
        .wr_addr                    (wr_addr),
        .wr_data                    (wr_data),
        .pmc_clr                    (pmc_clr),
        .busy                       (busy),
        .done                       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs[32];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          done_cyc, clr_cyc, done_cnt, clr_cnt;
    bit          busy_bad;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic set_basic_counters();
        stall_count = 256'h1F_0000_0007;
        cpi         = 256'h180;
        arith_count = 256'hA0;
        mem_count   = 256'h50;
    endtask

    // Requests one dump, then watches a fixed window, recording every transfer.
    task automatic run_dump(input logic clr, input int stall_idx, input int stall_len, input bit poke);
        int stalls_left;
        got_addr.delete();
        got_data.delete();
        done_cyc = -1; clr_cyc = -1; done_cnt = 0; clr_cnt = 0; busy_bad = 0;
        stalls_left = stall_len;
        @(negedge clk);
        dump_req    = 1'b1;
        clear_after = clr;
        wr_ready    = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            dump_req    = 1'b0;
            clear_after = 1'b0;
            if (pmc_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (done)    begin done_cnt++; done_cyc = cyc; end
            if (done_cyc < 0 && !busy) busy_bad = 1;
            if (poke && cyc == 3) begin
                stall_count = '1; cpi = '1; arith_count = '1; mem_count = '1;
                dump_req    = 1'b1;
                clear_after = 1'b1;
            end
            wr_ready = 1'b1;
            if (wr_valid && got_addr.size() == stall_idx && stalls_left > 0) begin
                wr_ready = 1'b0;
                stalls_left--;
                check("stall_addr", wr_addr, vecs[stall_idx].addr);
                check("stall_data", wr_data, vecs[stall_idx].data);
            end
            if (wr_valid && wr_ready) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
            end
        end
    endtask

    task automatic check_table(input string tag);
        check({tag, "_count"}, 32'(got_addr.size()), 32'd32);
        for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr[%0d]", tag, vecs[i].idx), got_addr[i], vecs[i].addr);
            check($sformatf("%s_data[%0d]", tag, vecs[i].idx), got_data[i], vecs[i].data);
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        bit seen;
        bit bad;
        // Expected stream for the basic counter set.
        for (int i = 0; i < 32; i++) begin
            vecs[i].idx  = i;
            vecs[i].addr = 32'h400 + 32'(4 * i);
            vecs[i].data = 32'h0;
        end
        vecs[0].data  = 32'h0000_0007;
        vecs[1].data  = 32'h0000_001F;
        vecs[8].data  = 32'h0000_0180;
        vecs[16].data = 32'h0000_00A0;
        vecs[24].data = 32'h0000_0050;

        // 1. reset with arbitrary inputs
        reset = 1'b1; dump_req = 1'b1; clear_after = 1'b1; wr_ready = 1'b1;
        stall_count = {8{$urandom}}; cpi = {8{$urandom}};
        arith_count = {8{$urandom}}; mem_count = {8{$urandom}};
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_addr",  wr_addr, 32'd0);
        check("rst_data",  wr_data, 32'd0);
        check("rst_clr",   32'(pmc_clr), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        dump_req = 1'b0; clear_after = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // 2. basic dump
        set_basic_counters();
        run_dump(1'b0, -1, 0, 1'b0);
        check_table("basic");
        check("basic_done_cyc", 32'(done_cyc), 32'd33);
        check("basic_clr_cnt",  32'(clr_cnt), 32'd0);

        // 3. backpressure at idx 5 for 3 cycles
        run_dump(1'b0, 5, 3, 1'b0);
        check_table("bp");
        check("bp_done_cyc", 32'(done_cyc), 32'd36);

        // 4. counters change and dump_req repeats during SEND
        set_basic_counters();
        run_dump(1'b0, -1, 0, 1'b1);
        check_table("iso");
        check("iso_clr_cnt", 32'(clr_cnt), 32'd0);

        // 5. clear after dump
        set_basic_counters();
        run_dump(1'b1, -1, 0, 1'b0);
        check_table("clr");
        check("clr_cnt", 32'(clr_cnt), 32'd1);
        check("clr_cyc", 32'(clr_cyc), 32'd33);
        check("clr_done_cyc", 32'(done_cyc), 32'd34);

        // 6. reset at idx 10 of a clear_after dump
        @(negedge clk);
        dump_req = 1'b1; clear_after = 1'b1; wr_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            dump_req = 1'b0; clear_after = 1'b0;
            if (wr_valid && wr_addr == 32'h428) seen = 1;
        end
        check("mid_reached_idx10", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_valid", 32'(wr_valid), 32'd0);
        check("mid_busy",  32'(busy), 32'd0);
        bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (pmc_clr || done || wr_valid) bad = 1;
        end
        check("mid_quiet", 32'(bad), 32'd0);
        stall_count = 256'hDEAD_BEEF_CAFE_F00D;
        cpi         = 256'h0;
        arith_count = 256'h0;
        mem_count   = 256'h1234_5678;
        run_dump(1'b0, -1, 0, 1'b0);
        check("re_count", 32'(got_addr.size()), 32'd32);
        if (got_addr.size() == 32) begin
            check("re_addr0",  got_addr[0],  32'h400);
            check("re_data0",  got_data[0],  32'hCAFE_F00D);
            check("re_data1",  got_data[1],  32'hDEAD_BEEF);
            check("re_data24", got_data[24], 32'h1234_5678);
            check("re_addr31", got_addr[31], 32'h47C);
        end
        check("re_done_cyc", 32'(done_cyc), 32'd33);
        check("re_clr_cnt",  32'(clr_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmc_dump_controller.md
Name: pmc_dump_controller

Overview:
Sequences readout of the PMC_unit performance counters: stall_count, cycles_per_instruction_q78, arith_count and mem_access_count.
- On request, captures all four 256-bit counters in one cycle into a snapshot register.
- Streams the snapshot as 32 consecutive 32-bit words over a valid/ready write port into the data-memory PMC dump region.
- Optionally pulses a clear to the PMC after the last word is accepted.
- Sits between the control path (dump trigger) and the PMC/data-memory write arbiter.

Parameters:
CNT_W, 256, width of each PMC counter
WORD_W, 32, width of the write data/address word
BASE_ADDR, 32'h0000_0400, byte address of dump word 0
WORDS_PER_CNT, CNT_W/WORD_W (8), derived, not overridden

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dump_req  in  1  start dump; sampled only in IDLE
clear_after  in  1  sampled with dump_req; 1 = pulse pmc_clr after dump
stall_count  in  CNT_W  PMC stall counter
cycles_per_instruction_q78  in  CNT_W  PMC CPI, Q7.8 fixed point
arith_count  in  CNT_W  PMC arithmetic-instruction counter
mem_access_count  in  CNT_W  PMC memory-access counter
wr_ready  in  1  sink accepts the current word
wr_valid  out  1  word on wr_addr/wr_data is valid
wr_addr  out  WORD_W  byte address of the current word
wr_data  out  WORD_W  current word
pmc_clr  out  1  one-cycle clear request to PMC
busy  out  1  dump in progress (SEND, CLEAR or DONE)
done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset: the synchronous, active-high reset applies on the next clk edge.
  - State goes to IDLE; idx=0; clr_pending=0; snapshot=0.
  - All outputs are 0: wr_valid, wr_addr, wr_data, pmc_clr, busy, done.
  - Reset mid-dump abandons the dump. No further words, no pmc_clr, no done.
- FSM states: IDLE, SEND, CLEAR, DONE.
- IDLE:
  - If dump_req=1: snapshot captures the counters in order {mem_access_count, arith_count, cycles_per_instruction_q78, stall_count}, with stall_count in the LSBs.
  - In the same cycle: idx<=0, clr_pending<=clear_after, next state SEND.
  - The capture is taken from counter values present in the cycle dump_req is sampled.
- SEND:
  - wr_valid=1.
  - wr_data = snapshot[idx*32 +: 32]. idx 0..7 = stall_count (word 0 = bits 31:0); 8..15 = CPI; 16..23 = arith; 24..31 = mem_access.
  - wr_addr = BASE_ADDR + 4*idx, with WORD_W-bit wrap.
  - A transfer occurs on wr_valid & wr_ready at the clk edge.
    - If idx<31: idx++.
    - If idx=31: go to CLEAR when clr_pending=1, else DONE.
  - While wr_ready=0, wr_addr and wr_data hold stable; wr_valid is never deasserted before a transfer.
  - wr_valid does not depend combinationally on wr_ready.
- CLEAR: pmc_clr=1 for exactly one cycle, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy: 1 in SEND, CLEAR and DONE; 0 in IDLE.
- Requests while busy:
  - dump_req and clear_after are ignored outside IDLE, including the DONE cycle. They are not queued.
  - A dump_req held high re-triggers in the first IDLE cycle.
- The snapshot is immune to counter changes after capture; the data streamed is the capture.
- Latency with wr_ready held at 1 and dump_req sampled at edge T:
  - Words are accepted at edges T+1..T+32.
  - done is high in the cycle after edge T+32 (clear_after=0), or after edge T+33 (clear_after=1).
  - pmc_clr is high in the cycle after edge T+32.
  - Each stalled cycle (wr_ready=0 while wr_valid=1) delays every later event by one cycle.

Test Plan:
1. Reset: assert reset for 2 cycles with arbitrary inputs -> all outputs 0; busy=0.
2. Basic dump:
   - Stimulus: stall_count=256'h1F_0000_0007, CPI=256'h180, arith=256'hA0, mem=256'h50; wr_ready=1; dump_req pulse with clear_after=0.
   - Required: 32 back-to-back transfers at wr_addr 0x400..0x47C.
   - Word 0=0x00000007, word 1=0x0000001F, word 8=0x00000180, word 16=0x000000A0, word 24=0x00000050; all other words 0.
   - done single pulse 1 cycle after the last transfer; pmc_clr never 1.
3. Backpressure:
   - Stimulus: drop wr_ready for 3 cycles while idx=5.
   - Required: wr_addr=0x414 and wr_data stable across the stall; transfer count stays 32; done 3 cycles later than in test 2.
4. Snapshot isolation and ignored request:
   - Stimulus: change all counters to all-ones and pulse dump_req again during SEND.
   - Required: streamed data equals the capture values; exactly one dump, 32 transfers.
5. Clear: dump with clear_after=1, wr_ready=1 -> pmc_clr high exactly 1 cycle immediately after the idx-31 transfer, then done 1 cycle later.
6. Reset mid-dump:
   - Stimulus: assert reset at idx=10 with clear_after=1; then issue a new dump_req.
   - Required: wr_valid=0 next cycle; no pmc_clr or done.
   - The new dump restarts at wr_addr 0x400 with a fresh capture.
